ultrasonic_dist_filter: RTL and testbench
=========================================

// Module: ultrasonic_dist_filter
// PURPOSE
//  Downstream of the ultrasonic measurement FSM. Takes each finished echo distance (cm),
//  rejects out-of-range readings and keeps a power-of-2 moving average. Converts the
//  average to 4 BCD digits with a sequential double-dabble, for the FND display mux.
//  dist_valid is the ultrasonic FSM's 1-cycle measurement-done strobe; dist_in is its echo_cnt_out.
// PARAMETERS
//  W          14   width of dist_in / avg_cm
//  AVG_LOG2   2    log2 of averaging window (4 samples)
//  MIN_CM     2    smallest accepted distance, inclusive
//  MAX_CM     400  largest accepted distance, inclusive; must be <= 9999
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset (0 = reset)
//  dist_in      in   W   measured distance, cm
//  dist_valid   in   1   1-cycle strobe, dist_in valid
//  busy         out  1   1 while a sample is being processed (state != IDLE)
//  avg_cm       out  W   last published average, cm
//  bcd          out  16  {thousands,hundreds,tens,ones} of avg_cm
//  out_valid    out  1   1-cycle pulse when avg_cm/bcd update
//  out_of_range out  1   1 while the last accepted strobe was outside [MIN_CM,MAX_CM]
//  overrun      out  1   sticky; strobe arrived while busy; cleared by next in-range accept
// BEHAVIOUR
//  - Reset: all outputs 0, buffer/sum 0, primed=0, state IDLE. Reset mid-operation aborts
//    the conversion and publishes nothing.
//  - FSM: IDLE -> ACCUM -> CONVERT -> DONE -> IDLE.
//  - IDLE: on dist_valid, check range first.
//    - Out of range: out_of_range=1 on the next cycle. Stay IDLE. No out_valid.
//      Buffer, sum, avg_cm and bcd are unchanged.
//    - In range: latch dist_in, clear out_of_range and overrun, go ACCUM.
//  - ACCUM, 1 cycle:
//    - If !primed: write the sample to all 2^AVG_LOG2 entries, sum = sample << AVG_LOG2, primed=1.
//    - Else: sum = sum - buf[wr_ptr] + sample; buf[wr_ptr] = sample; wr_ptr++ (wraps mod 2^AVG_LOG2).
//    - sum width W+AVG_LOG2, never overflows.
//  - CONVERT, exactly W cycles:
//    - Load avg = sum >> AVG_LOG2 (truncation, no rounding).
//    - Each cycle: add 3 to any BCD nibble >=5, then shift left 1 with the next avg MSB.
//  - DONE, 1 cycle: avg_cm and bcd register together, out_valid=1, then IDLE.
//  - Latency: strobe accepted in cycle T -> out_valid high in cycle T+W+2 (16 at defaults).
//    Throughput: one sample per W+3 cycles.
//  - dist_valid while busy: sample dropped, overrun=1, pipeline undisturbed.
//  - avg_cm/bcd hold between updates. bcd never exceeds digit 9.
// STRUCTURE
//  - ultrasonic_pkg:
//    - state enum {IDLE, ACCUM, CONVERT, DONE}
//    - DIST_W=14, MIN_CM/MAX_CM defaults
//  - Sub-module bin2bcd_seq (start, bin[W-1:0] -> bcd[15:0], done), iterative double-dabble.
//    Top holds the FSM, range check, circular buffer and running sum.
// TESTING
//  1. Reset, strobe 100 -> out_valid at T+16, avg_cm=100, bcd=16'h0100, busy high T+1..T+16.
//  2. Prime 100, then 100,100,200 -> avg_cm 100,100,125. Last bcd=16'h0125.
//  3. Prime 10, then 11,11,11 -> sum 43, avg_cm=10 (truncation). Next 11 -> 11.
//  4. Strobe 500, then 1 -> out_of_range=1 next cycle, no out_valid, avg_cm unchanged.
//     Then strobe 50 -> out_of_range=0.
//  5. Strobe 60, second strobe 70 at T+5 -> 70 dropped, overrun=1, out_valid once at T+16.
//     Next accepted strobe clears overrun.
//  6. Assert reset at T+8 mid-CONVERT -> outputs 0, no out_valid.
//     Next strobe 30 re-primes -> avg_cm=30.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types, default parameters and the double-dabble step used by the
// ultrasonic distance filter.
package ultrasonic_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, DONE} state_e;

  localparam int DIST_W       = 14;
  localparam int AVG_LOG2_DEF = 2;
  localparam int MIN_CM_DEF   = 2;
  localparam int MAX_CM_DEF   = 400;

  // One double-dabble iteration: +3 on every digit >= 5, then shift in bit_in.
  function automatic logic [15:0] dabble_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    return {adj[14:0], bit_in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter: one bit per cycle, W cycles after i_start.
// o_done flags the last shift; o_bcd carries the final digits in that cycle.
module bin2bcd_seq
  import ultrasonic_pkg::*;
#(
  parameter int W = DIST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_bin,
  output logic [15:0]  o_bcd,
  output logic         o_done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_bin;
  logic [15:0]   r_bcd;
  logic [CW-1:0] r_cnt;
  logic [15:0]   w_shift;

  assign w_shift = dabble_step(r_bcd, r_bin[W-1]);
  assign o_bcd   = w_shift;
  assign o_done  = (r_cnt == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= i_bin;
      r_bcd <= '0;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_shift;
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/ultrasonic_dist_filter.sv
// Range-checks ultrasonic echo distances, keeps a 2^AVG_LOG2-sample moving
// average and publishes it in binary and BCD.
module ultrasonic_dist_filter
  import ultrasonic_pkg::*;
#(
  parameter int W        = DIST_W,
  parameter int AVG_LOG2 = AVG_LOG2_DEF,
  parameter int MIN_CM   = MIN_CM_DEF,
  parameter int MAX_CM   = MAX_CM_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] dist_in,
  input  logic         dist_valid,
  output logic         busy,
  output logic [W-1:0] avg_cm,
  output logic [15:0]  bcd,
  output logic         out_valid,
  output logic         out_of_range,
  output logic         overrun
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = W + AVG_LOG2;
  localparam logic [W-1:0] MIN_V = W'(MIN_CM);
  localparam logic [W-1:0] MAX_V = W'(MAX_CM);

  state_e r_state, w_state_next;

  logic [W-1:0]        r_buf [DEPTH];
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [SW-1:0]       r_sum, w_sum_next;
  logic [W-1:0]        r_sample, r_avg, r_avg_cm;
  logic [15:0]         r_bcd, w_bcd;
  logic                r_primed, r_oor, r_overrun;
  logic                w_in_range, w_start, w_bcd_done;

  assign w_in_range   = (dist_in >= MIN_V) && (dist_in <= MAX_V);
  assign avg_cm       = r_avg_cm;
  assign bcd          = r_bcd;
  assign out_of_range = r_oor;
  assign overrun      = r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (dist_valid && w_in_range) w_state_next = ACCUM;
      ACCUM:   w_state_next = CONVERT;
      CONVERT: if (w_bcd_done) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    out_valid = (r_state == DONE);
    w_start   = (r_state == ACCUM);
  end

  // First sample fills the whole window so the average is meaningful at once.
  always_comb begin
    w_sum_next = r_sum;
    if (r_primed) w_sum_next = r_sum - SW'(r_buf[r_wr_ptr]) + SW'(r_sample);
    else          w_sum_next = SW'(r_sample) << AVG_LOG2;
  end

  // NOTE: the sample buffer is reset explicitly; it is tiny, and a defined
  // power-up window keeps the running sum consistent with its contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr  <= '0;
      r_sum     <= '0;
      r_sample  <= '0;
      r_avg     <= '0;
      r_avg_cm  <= '0;
      r_bcd     <= '0;
      r_primed  <= 1'b0;
      r_oor     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (dist_valid) begin
        if (r_state != IDLE) begin
          r_overrun <= 1'b1;
        end else if (w_in_range) begin
          r_sample  <= dist_in;
          r_oor     <= 1'b0;
          r_overrun <= 1'b0;
        end else begin
          r_oor <= 1'b1;
        end
      end
      if (r_state == ACCUM) begin
        if (r_primed) begin
          r_buf[r_wr_ptr] <= r_sample;
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) r_buf[i] <= r_sample;
          r_primed <= 1'b1;
        end
        r_sum <= w_sum_next;
        r_avg <= w_sum_next[SW-1:AVG_LOG2];
      end
      if ((r_state == CONVERT) && w_bcd_done) begin
        r_avg_cm <= r_avg;
        r_bcd    <= w_bcd;
      end
    end
  end

  bin2bcd_seq #(.W(W)) u_bin2bcd (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_start),
    .i_bin   (w_sum_next[SW-1:AVG_LOG2]),
    .o_bcd   (w_bcd),
    .o_done  (w_bcd_done)
  );

endmodule

// File: tb/tb_ultrasonic_dist_filter.sv
// Self-checking bench: directed scenarios plus randomized strobes compared
// against a sliding-window average model.
module tb_ultrasonic_dist_filter;

  localparam int LO  = 2;
  localparam int HI  = 400;
  localparam int LAT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [13:0] dist_in = '0;
  logic        dist_valid = 1'b0;
  logic        busy, out_valid, out_of_range, overrun;
  logic [13:0] avg_cm;
  logic [15:0] bcd;

  int n_checks = 0;
  int n_errors = 0;

  int          win[$];
  bit          primed;
  logic [13:0] exp_avg;
  logic [15:0] exp_bcd;
  logic        exp_oor, exp_ovr;

  ultrasonic_dist_filter dut (
    .clk          (clk),
    .reset        (reset),
    .dist_in      (dist_in),
    .dist_valid   (dist_valid),
    .busy         (busy),
    .avg_cm       (avg_cm),
    .bcd          (bcd),
    .out_valid    (out_valid),
    .out_of_range (out_of_range),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    win.delete();
    primed  = 0;
    exp_avg = '0;
    exp_bcd = '0;
    exp_oor = 0;
    exp_ovr = 0;
  endtask

  task automatic model_strobe(input int d);
    int s;
    if (d >= LO && d <= HI) begin
      if (!primed) begin
        win    = {d, d, d, d};
        primed = 1;
      end else begin
        void'(win.pop_front());
        win.push_back(d);
      end
      s = 0;
      foreach (win[i]) s += win[i];
      exp_avg = 14'(s / 4);
      exp_bcd = to_bcd(s / 4);
      exp_oor = 0;
      exp_ovr = 0;
    end else begin
      exp_oor = 1;
    end
  endtask

  // Drives one strobe, optionally a second one at cycle inj_k, and observes n_obs cycles.
  task automatic run_sample(input logic [13:0] d, input int n_obs, input int inj_k,
                            input logic [13:0] inj_d, output int ov_cnt, output int ov_first,
                            output int busy_cnt, output logic oor_k1);
    ov_cnt = 0; ov_first = -1; busy_cnt = 0; oor_k1 = 1'b0;
    @(negedge clk);
    dist_in    = d;
    dist_valid = 1'b1;
    for (int k = 1; k <= n_obs; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        ov_cnt++;
        if (ov_first < 0) ov_first = k;
      end
      if (busy === 1'b1) busy_cnt++;
      if (k == 1) oor_k1 = out_of_range;
      dist_valid = (k == inj_k);
      if (k == inj_k) dist_in = inj_d;
    end
    dist_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({busy, out_valid, out_of_range, overrun, avg_cm, bcd} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got busy=%b ov=%b oor=%b ovr=%b avg=%0d bcd=%h want all 0",
               busy, out_valid, out_of_range, overrun, avg_cm, bcd);
    end
  endtask

  task automatic test_first_sample();
    int c, f, b; logic o;
    run_sample(14'd100, 20, 0, '0, c, f, b, o);
    model_strobe(100);
    n_checks++;
    if (c != 1 || f != LAT) begin
      n_errors++; $display("FAIL first_latency got count=%0d cycle=%0d want 1 at %0d", c, f, LAT);
    end
    n_checks++;
    if (b != LAT) begin
      n_errors++; $display("FAIL first_busy got %0d busy cycles want %0d", b, LAT);
    end
    n_checks++;
    if (avg_cm !== 14'd100 || bcd !== 16'h0100) begin
      n_errors++; $display("FAIL first_value got avg=%0d bcd=%h want 100 0100", avg_cm, bcd);
    end
  endtask

  task automatic test_average();
    int c, f, b; logic o;
    int seq[3] = '{100, 100, 200};
    foreach (seq[i]) begin
      run_sample(14'(seq[i]), 20, 0, '0, c, f, b, o);
      model_strobe(seq[i]);
      n_checks++;
      if (avg_cm !== exp_avg || bcd !== exp_bcd || c != 1) begin
        n_errors++;
        $display("FAIL average_%0d got avg=%0d bcd=%h pulses=%0d want avg=%0d bcd=%h pulses=1",
                 i, avg_cm, bcd, c, exp_avg, exp_bcd);
      end
    end
    n_checks++;
    if (avg_cm !== 14'd125 || bcd !== 16'h0125) begin
      n_errors++; $display("FAIL average_final got avg=%0d bcd=%h want 125 0125", avg_cm, bcd);
    end
  endtask

  task automatic test_truncation();
    int c, f, b; logic o;
    int seq[5] = '{10, 11, 11, 11, 11};
    int want[5] = '{10, 10, 10, 10, 11};
    do_reset();
    foreach (seq[i]) begin
      run_sample(14'(seq[i]), 20, 0, '0, c, f, b, o);
      model_strobe(seq[i]);
      n_checks++;
      if (avg_cm !== 14'(want[i]) || avg_cm !== exp_avg || bcd !== exp_bcd) begin
        n_errors++;
        $display("FAIL truncation_%0d got avg=%0d bcd=%h want avg=%0d bcd=%h",
                 i, avg_cm, bcd, want[i], exp_bcd);
      end
    end
  endtask

  task automatic test_out_of_range();
    int c, f, b; logic o;
    int seq[3] = '{500, 1, 50};
    foreach (seq[i]) begin
      run_sample(14'(seq[i]), 20, 0, '0, c, f, b, o);
      model_strobe(seq[i]);
      n_checks++;
      if (o !== exp_oor || out_of_range !== exp_oor) begin
        n_errors++;
        $display("FAIL range_flag_%0d got next=%b later=%b want %b", seq[i], o, out_of_range, exp_oor);
      end
      n_checks++;
      if (c != (exp_oor ? 0 : 1) || avg_cm !== exp_avg || bcd !== exp_bcd) begin
        n_errors++;
        $display("FAIL range_publish_%0d got pulses=%0d avg=%0d bcd=%h want avg=%0d bcd=%h",
                 seq[i], c, avg_cm, bcd, exp_avg, exp_bcd);
      end
    end
  endtask

  task automatic test_overrun();
    int c, f, b; logic o;
    run_sample(14'd60, 20, 5, 14'd70, c, f, b, o);
    model_strobe(60);
    n_checks++;
    if (overrun !== 1'b1) begin
      n_errors++; $display("FAIL overrun_set got %b want 1", overrun);
    end
    n_checks++;
    if (c != 1 || f != LAT || avg_cm !== exp_avg || bcd !== exp_bcd) begin
      n_errors++;
      $display("FAIL overrun_pipeline got pulses=%0d cycle=%0d avg=%0d want 1 at %0d avg=%0d",
               c, f, avg_cm, LAT, exp_avg);
    end
    run_sample(14'd80, 20, 0, '0, c, f, b, o);
    model_strobe(80);
    n_checks++;
    if (overrun !== 1'b0 || avg_cm !== exp_avg) begin
      n_errors++;
      $display("FAIL overrun_clear got ovr=%b avg=%0d want 0 avg=%0d", overrun, avg_cm, exp_avg);
    end
  endtask

  task automatic test_reset_mid_convert();
    int c, f, b; logic o;
    int pulses = 0;
    @(negedge clk);
    dist_in    = 14'd200;
    dist_valid = 1'b1;
    @(negedge clk);
    dist_valid = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, out_of_range, overrun, avg_cm, bcd} !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs got busy=%b avg=%0d bcd=%h want all 0", busy, avg_cm, bcd);
    end
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0 || avg_cm !== '0) begin
      n_errors++; $display("FAIL midreset_publish got pulses=%0d avg=%0d want 0 0", pulses, avg_cm);
    end
    run_sample(14'd30, 20, 0, '0, c, f, b, o);
    model_strobe(30);
    n_checks++;
    if (avg_cm !== 14'd30 || bcd !== 16'h0030 || avg_cm !== exp_avg) begin
      n_errors++; $display("FAIL midreset_reprime got avg=%0d bcd=%h want 30 0030", avg_cm, bcd);
    end
  endtask

  task automatic test_back_to_back();
    int c, f, b; logic o;
    for (int i = 0; i < 6; i++) begin
      int d = int'($urandom_range(LO, HI));
      run_sample(14'(d), 16, 0, '0, c, f, b, o);
      model_strobe(d);
      n_checks++;
      if (c != 1 || f != LAT || overrun !== 1'b0 || avg_cm !== exp_avg || bcd !== exp_bcd) begin
        n_errors++;
        $display("FAIL back_to_back_%0d got pulses=%0d cycle=%0d ovr=%b avg=%0d bcd=%h want avg=%0d bcd=%h",
                 i, c, f, overrun, avg_cm, bcd, exp_avg, exp_bcd);
      end
    end
  endtask

  task automatic test_random();
    int c, f, b; logic o;
    for (int i = 0; i < 30; i++) begin
      int d;
      if ($urandom_range(0, 4) == 0) d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1))
                                                                     : int'($urandom_range(401, 2000));
      else d = int'($urandom_range(LO, HI));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sample(14'(d), 20, 0, '0, c, f, b, o);
      model_strobe(d);
      n_checks++;
      if (o !== exp_oor || c != (exp_oor ? 0 : 1) || (!exp_oor && f != LAT) ||
          avg_cm !== exp_avg || bcd !== exp_bcd) begin
        n_errors++;
        $display("FAIL random_%0d in=%0d got oor=%b pulses=%0d cycle=%0d avg=%0d bcd=%h want oor=%b avg=%0d bcd=%h",
                 i, d, o, c, f, avg_cm, bcd, exp_oor, exp_avg, exp_bcd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_average();
    test_truncation();
    test_out_of_range();
    test_overrun();
    test_reset_mid_convert();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
